// File: rtl/if_id_skid_if.sv
// Handshake bundle between fetch, the IF/ID skid queue and decode.
// Signal names keep the stage's _i/_o view so both sides read the same way.
interface if_id_skid_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [ADDR_W-1:0] pc_i;
  logic [INST_W-1:0] inst_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic [CNT_W-1:0]  count_o;

  // Environment side: fetch, branch unit and decode.
  modport master (
    output in_valid_i, pc_i, inst_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, inst_o, count_o
  );

  // The queue itself.
  modport slave (
    input  in_valid_i, pc_i, inst_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, inst_o, count_o
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID decoupling queue: DEPTH-entry in-order FIFO of {pc, inst} with branch flush.
// Presents a NOP bubble carrying the last pushed / redirect PC whenever empty.
module if_id_skid #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
  input logic         clk,
  input logic         rst,
  if_id_skid_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = ADDR_W + INST_W;

  logic [EntW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [EntW-1:0]   head;
  logic              full, empty, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // Both handshakes look only at registered count; no out_ready -> in_ready path.
  assign push  = bus.in_valid_i && !full && !bus.flush_i;
  assign pop   = !empty && bus.out_ready_i && !bus.flush_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    if (bus.flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      last_pc_d = bus.pc_i;
    end else begin
      if (push) begin
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        last_pc_d = bus.pc_i;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Slot contents survive flush and reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.pc_i, bus.inst_i};
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.in_ready_o  = !full && rst;
  assign bus.out_valid_o = !empty;
  assign bus.pc_o        = empty ? last_pc_q : head[EntW-1:INST_W];
  assign bus.inst_o      = empty ? NOP_INST : head[INST_W-1:0];
  assign bus.count_o     = count_q;
endmodule

// File: tb/tb_if_id_skid.sv
// Drives identical traffic into a DEPTH=2 and a DEPTH=4 queue and checks both
// every cycle against a shift-array FIFO model of the stage.
module tb_if_id_skid;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;

  if_id_skid_if #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) bus2 ();
  if_id_skid_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) bus4 ();

  assign bus2.in_valid_i  = in_valid;
  assign bus2.pc_i        = pc_in;
  assign bus2.inst_i      = inst_in;
  assign bus2.flush_i     = flush;
  assign bus2.out_ready_i = out_ready;
  assign bus4.in_valid_i  = in_valid;
  assign bus4.pc_i        = pc_in;
  assign bus4.inst_i      = inst_in;
  assign bus4.flush_i     = flush;
  assign bus4.out_ready_i = out_ready;

  if_id_skid #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  if_id_skid #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  // Model: entry 0 is the head; pops shift everything down.
  int          depth [2] = '{2, 4};
  logic [63:0] mq [2][8];
  int          mn [2] = '{0, 0};
  logic [31:0] mlast [2] = '{32'h0, 32'h0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    logic        rdy, vld;
    logic [31:0] opc, oinst, epc, einst;
    int          ocnt;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        rdy = bus2.in_ready_o; vld = bus2.out_valid_o; opc = bus2.pc_o;
        oinst = bus2.inst_o; ocnt = int'(bus2.count_o);
      end else begin
        rdy = bus4.in_ready_o; vld = bus4.out_valid_o; opc = bus4.pc_o;
        oinst = bus4.inst_o; ocnt = int'(bus4.count_o);
      end
      epc   = (mn[k] != 0) ? mq[k][0][63:32] : mlast[k];
      einst = (mn[k] != 0) ? mq[k][0][31:0] : Nop;
      chk($sformatf("%s d%0d in_ready", ph, depth[k]), 64'(rdy), 64'((mn[k] != depth[k]) && rst));
      chk($sformatf("%s d%0d out_valid", ph, depth[k]), 64'(vld), 64'(mn[k] != 0));
      chk($sformatf("%s d%0d pc", ph, depth[k]), 64'(opc), 64'(epc));
      chk($sformatf("%s d%0d inst", ph, depth[k]), 64'(oinst), 64'(einst));
      chk($sformatf("%s d%0d count", ph, depth[k]), 64'(ocnt), 64'(mn[k]));
    end
  endtask

  task automatic model_edge();
    bit push, pop;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mn[k] = 0;
        mlast[k] = '0;
      end else if (flush) begin
        mn[k] = 0;
        mlast[k] = pc_in;
      end else begin
        push = in_valid && (mn[k] != depth[k]);
        pop  = out_ready && (mn[k] != 0);
        if (pop) begin
          for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
        end
        if (push) begin
          mq[k][mn[k]] = {pc_in, inst_in};
          mn[k]++;
          mlast[k] = pc_in;
        end
      end
    end
  endtask

  // Entered at posedge+1 with inputs set; checks mid-cycle, then advances the model.
  task automatic cycle(input string ph);
    #3;
    check_outputs(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic ordy);
    in_valid  = v;
    pc_in     = pc;
    inst_in   = $urandom;
    flush     = fl;
    out_ready = ordy;
  endtask

  logic [31:0] rpc;

  initial begin
    #2;
    check_outputs("reset");
    #5;
    rst = 1'b1;
    #1;
    check_outputs("rst_release");

    // Fill with decode stalled; third offer refused by the 2-deep queue.
    drive(1'b1, 32'h100, 1'b0, 1'b0); cycle("fill0");
    drive(1'b1, 32'h104, 1'b0, 1'b0); cycle("fill1");
    drive(1'b1, 32'h108, 1'b0, 1'b0); cycle("fill2");
    drive(1'b0, 32'h0, 1'b0, 1'b0);   cycle("fill3");
    drive(1'b0, 32'h0, 1'b1, 1'b0);   cycle("clr0");

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b1);
      cycle("stream");
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1); cycle("stream_end");

    // Full queue with a simultaneous pop: the offer waits a cycle.
    drive(1'b1, 32'h200, 1'b0, 1'b0); cycle("fullpop0");
    drive(1'b1, 32'h204, 1'b0, 1'b0); cycle("fullpop1");
    drive(1'b1, 32'h208, 1'b0, 1'b1); cycle("fullpop2");
    drive(1'b1, 32'h208, 1'b0, 1'b1); cycle("fullpop3");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cycle("fullpop_drain");
    end

    // Flush with an offer pending: bubble carries the redirect PC.
    drive(1'b1, 32'h300, 1'b0, 1'b0); cycle("flush_fill0");
    drive(1'b1, 32'h304, 1'b0, 1'b0); cycle("flush_fill1");
    drive(1'b1, 32'h400, 1'b1, 1'b1); cycle("flush");
    drive(1'b0, 32'h0, 1'b0, 1'b0);   cycle("after_flush");
    drive(1'b1, 32'h500, 1'b0, 1'b1); cycle("first_push");
    drive(1'b0, 32'h0, 1'b0, 1'b1);   cycle("first_push_out");

    // Pointer wrap: 10 pushes with decode stalling every other cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'(i % 2));
      cycle("wrap");
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      cycle("wrap_drain");
    end

    rpc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7), rpc, 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 9) < 6));
      rpc = rpc + 32'h4;
      cycle("random");
    end

    // Asynchronous reset between edges with three entries queued.
    drive(1'b0, 32'h0, 1'b1, 1'b0); cycle("pre_rst_flush");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(i * 4), 1'b0, 1'b0);
      cycle("pre_rst_fill");
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0;
      mlast[k] = '0;
    end
    #1;
    check_outputs("async_rst");
    #1;
    rst = 1'b1;
    #1;
    check_outputs("async_rel");
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), rpc, 1'b0, 1'($urandom_range(0, 1)));
      rpc = rpc + 32'h4;
      cycle("post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
